muldiv_unit: RTL

Iterative RV32M/RV64M multiply-divide unit for the execute stage of the pipelined RISC-V core. It sits beside the single-cycle ALU and its operation decoder. It decodes the M-extension encoding from the same ALUOp/Funct7/Funct3 fields and runs multi-cycle shift-add multiplication and restoring division. It holds the pipeline through a busy/done handshake and supports flush for branch and exception squash.

---
 rtl/muldiv_unit.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide, one step per clock, with busy/done
// handshake and flush. Optional MULDIV_FAST_MUL_EN selects a single-cycle
// combinational multiplier; divides stay iterative.
module muldiv_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_reset_n,
   input  logic            i_start,
   input  logic [1:0]      i_alu_op,
   input  logic [6:0]      i_funct7,
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_src_a,
   input  logic [XLEN-1:0] i_src_b,
   input  logic            i_flush,
   output logic            o_is_muldiv,
   output logic            o_busy,
   output logic            o_done,
   output logic [XLEN-1:0] o_result
);

   localparam int unsigned CW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

   state_e              r_state, w_state_next;
   logic [2*XLEN-1:0]   r_acc;     // {remainder, quotient} or {product hi, lo}
   logic [XLEN-1:0]     r_b;       // multiplicand / divisor magnitude
   logic [2:0]          r_op;
   logic                r_neg;     // negate the selected result in FIX
   logic [CW-1:0]       r_cnt;
   logic [XLEN-1:0]     r_result;

   logic                w_accept;
   logic                w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_res_neg;
   logic [XLEN-1:0]     w_a_mag, w_b_mag;
   logic [XLEN:0]       w_mul_sum, w_rem_shift, w_diff;
   logic [2*XLEN-1:0]   w_mul_step, w_div_step, w_prod_fix;
   logic [XLEN-1:0]     w_quo_fix, w_rem_fix, w_fix_result;
`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0]   w_fast_prod;
`endif

   assign o_is_muldiv = (i_alu_op == 2'b10) && (i_funct7 == 7'b0000001);
   assign w_accept    = i_start && o_is_muldiv && !i_flush &&
                        ((r_state == StIdle) || (r_state == StDone));

   // Operand signedness per Funct3; MUL treats both as signed (low half is identical).
   always_comb begin
      w_a_signed = 1'b0;
      w_b_signed = 1'b0;
      unique case (i_funct3)
         3'b000, 3'b001, 3'b100, 3'b110: begin
            w_a_signed = 1'b1;
            w_b_signed = 1'b1;
         end
         3'b010:  w_a_signed = 1'b1;
         default: ;
      endcase
   end

   assign w_a_neg = w_a_signed & i_src_a[XLEN-1];
   assign w_b_neg = w_b_signed & i_src_b[XLEN-1];
   assign w_a_mag = w_a_neg ? -i_src_a : i_src_a;
   assign w_b_mag = w_b_neg ? -i_src_b : i_src_b;

   // Result sign: DIV quotient keeps all-ones on divide by zero; REM follows dividend.
   always_comb begin
      w_res_neg = w_a_neg ^ w_b_neg;
      if (i_funct3 == 3'b100) begin
         w_res_neg = (w_a_neg ^ w_b_neg) && (|i_src_b);
      end else if (i_funct3 == 3'b110) begin
         w_res_neg = w_a_neg;
      end
   end

`ifdef MULDIV_FAST_MUL_EN
   assign w_fast_prod = {{XLEN{1'b0}}, w_a_mag} * {{XLEN{1'b0}}, w_b_mag};
`endif

   // One shift-add step: add multiplicand into the high half when the LSB is set.
   assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
   assign w_mul_step = {w_mul_sum, r_acc[XLEN-1:1]};

   // One restoring-divide step: shift in the next dividend bit, trial subtract.
   assign w_rem_shift = r_acc[2*XLEN-1:XLEN-1];
   assign w_diff      = w_rem_shift - {1'b0, r_b};
   assign w_div_step  = w_diff[XLEN] ? {w_rem_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                     : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

   assign w_prod_fix = r_neg ? -r_acc : r_acc;
   assign w_quo_fix  = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
   assign w_rem_fix  = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

   // Select the sign-corrected result for the latched op.
   always_comb begin
      w_fix_result = '0;
      unique case (r_op)
         3'b000:                 w_fix_result = w_prod_fix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: w_fix_result = w_prod_fix[2*XLEN-1:XLEN];
         3'b100, 3'b101:         w_fix_result = w_quo_fix;
         default:                w_fix_result = w_rem_fix;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; flush overrides everything.
   always_comb begin
      w_state_next = r_state;
      if (i_flush) begin
         w_state_next = StIdle;
      end else begin
         unique case (r_state)
            StIdle, StDone: begin
               if (w_accept) begin
`ifdef MULDIV_FAST_MUL_EN
                  w_state_next = i_funct3[2] ? StRun : StFix;
`else
                  w_state_next = StRun;
`endif
               end else begin
                  w_state_next = StIdle;
               end
            end
            StRun: begin
               if (r_cnt == CW'(XLEN - 1)) begin
                  w_state_next = StFix;
               end
            end
            default: w_state_next = StDone;
         endcase
      end
   end

   // Datapath: latch on accept, iterate in RUN, write result in FIX.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_acc    <= '0;
         r_b      <= '0;
         r_op     <= '0;
         r_neg    <= 1'b0;
         r_cnt    <= '0;
         r_result <= '0;
      end else if (w_accept) begin
`ifdef MULDIV_FAST_MUL_EN
         r_acc <= i_funct3[2] ? {{XLEN{1'b0}}, w_a_mag} : w_fast_prod;
`else
         r_acc <= {{XLEN{1'b0}}, w_a_mag};
`endif
         r_b   <= w_b_mag;
         r_op  <= i_funct3;
         r_neg <= w_res_neg;
         r_cnt <= '0;
      end else if (!i_flush && (r_state == StRun)) begin
         r_acc <= r_op[2] ? w_div_step : w_mul_step;
         r_cnt <= r_cnt + 1'b1;
      end else if (!i_flush && (r_state == StFix)) begin
         r_result <= w_fix_result;
      end
   end

   assign o_busy   = (r_state == StRun) || (r_state == StFix);
   assign o_done   = (r_state == StDone);
   assign o_result = r_result;

endmodule
